dac_stream_player: RTL and testbench
====================================

Name: dac_stream_player

Overview:
- Downstream consumer of the PC-data FIFO read port (16-bit words, show-ahead OFF: q valid the cycle after rdreq).
- Paces samples out to the 14-bit DAC bus at a programmable rate.
- Prefetches one word to hide FIFO read latency.
- Handles end-of-stream marker, underrun detection and stop.

Parameters:
- DIV_W, 16, width of rate divider.
- IDLE_CODE, 14'h2000, DAC code driven after reset/stop (mid-scale).

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse, begin playback.
- stop  in  1  one-cycle pulse, abort playback.
- rate_div  in  DIV_W  sample period minus 1, latched at start.
- fifo_q  in  16  FIFO read data; [13:0] sample, [14] reserved/ignored, [15] last-sample flag.
- fifo_empty  in  1  FIFO read-side empty.
- fifo_rdreq  out  1  FIFO read request.
- dac_d  out  14  DAC code.
- dac_strobe  out  1  one-cycle pulse when dac_d updates with a new sample.
- busy  out  1  high in PRIME/RUN.
- done  out  1  one-cycle pulse after the last-flagged sample is emitted.
- underrun  out  1  sticky; set when a sample tick finds no buffered word.
- sample_cnt  out  24  samples emitted since start, wraps at 2^24.

Behaviour:
- Interface: one clock, sys_clk; reset rst is synchronous and active-high.
- Reset values: dac_d=IDLE_CODE; fifo_rdreq, dac_strobe, busy, done, underrun = 0; sample_cnt=0; state IDLE; buffer invalid; no read pending.
- States:
  - IDLE: start → PRIME; latch per = max(rate_div,1); clear underrun and sample_cnt.
  - PRIME: when !fifo_empty, assert rdreq (pend=1). Next cycle capture fifo_q into buf, valid=1, then → RUN with div counter=0.
  - RUN:
    - Tick occurs when counter==0; counter then reloads per, otherwise decrements. Sample period = per+1 cycles.
    - Tick with valid: dac_d<=buf[13:0], dac_strobe=1, valid<=0, sample_cnt+1.
    - If buf[15]=1 on that tick: → IDLE next cycle, done=1 for one cycle. dac_d holds the last sample.
    - Tick without valid: underrun<=1, dac_d holds, no strobe, counter reloads normally.
- Refill rule:
  - fifo_rdreq = state∈{PRIME,RUN} && !pend && !fifo_empty && (!valid || tick-consuming-buf) && !(valid && buf[15]).
  - Never read past a buffered last-flagged word.
  - pend clears the cycle data is captured.
- Throughput: per≥1 guarantees a one-word buffer sustains every tick with a non-empty FIFO. rate_div=0 is treated as 1.
- stop:
  - In any state: → IDLE next edge; dac_d<=IDLE_CODE; valid<=0; pend<=0.
  - Data returned for an in-flight read is discarded.
  - No done pulse; underrun and sample_cnt retained.
- Simultaneous events:
  - start+stop same cycle: stop wins, stay IDLE.
  - start while busy: ignored.
  - rst overrides all.
- fifo_empty in PRIME: wait indefinitely; no underrun (ticks start only in RUN).

Test Plan:
- Reset: rst high 2 cycles → dac_d=0x2000, all flags 0, sample_cnt=0.
- Steady stream: FIFO preloaded with 0x0001..0x0004 (0x8004 last), rate_div=3 → strobes every 4 cycles, dac_d=1,2,3,4; done 1 cycle after 4th strobe; sample_cnt=4; underrun=0; rdreq never issued after 0x8004 fetched.
- Max rate: rate_div=0, 8 words in FIFO → strobe every 2 cycles, no underrun.
- Underrun: 2 words (no last flag), rate_div=2 → after 2 strobes, next tick sets underrun=1, dac_d holds 2nd value, no strobe. Pushing a word later resumes strobes; underrun stays 1.
- Stop mid-stream: stop issued the cycle after an rdreq → next cycle dac_d=0x2000, busy=0, returned word discarded; a new start fetches the following FIFO word.
- Edge cases:
  - start+stop same cycle → remains IDLE, no rdreq.
  - start during RUN → no effect on period or sample_cnt.

Source files
------------

// File: rtl/dac_stream_player_if.sv
// FIFO read port and DAC bus of the stream player.
// master: the player (issues reads, drives the DAC); slave: FIFO/DAC side.
interface dac_stream_player_if;
  logic [15:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic [13:0] dac_d;
  logic        dac_strobe;

  modport master (
    input  fifo_q,
    input  fifo_empty,
    output fifo_rdreq,
    output dac_d,
    output dac_strobe
  );

  modport slave (
    output fifo_q,
    output fifo_empty,
    input  fifo_rdreq,
    input  dac_d,
    input  dac_strobe
  );
endinterface

// File: rtl/dac_stream_player.sv
// Paces 14-bit samples from a non-show-ahead FIFO to a DAC at a programmable
// rate. A one-word buffer is prefetched so FIFO read latency is hidden; bit 15
// of a word marks the last sample of a stream.
module dac_stream_player #(
  parameter int unsigned DIV_W     = 16,
  parameter logic [13:0] IDLE_CODE = 14'h2000
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_W-1:0]     rate_div,
  dac_stream_player_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun,
  output logic [23:0]          sample_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] per_q;
  logic [DIV_W-1:0] cnt_q;
  logic [13:0]      buf_q;
  logic             buf_last_q;
  logic             valid_q;
  logic             pend_q;
  logic             emit_last_q;
  logic             tick;
  logic             consume;
  logic             rd;

  assign busy           = (state_q != S_IDLE);
  assign bus.fifo_rdreq = rd;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sample tick, refill request and next-state decode.
  always_comb begin
    tick    = 1'b0;
    consume = 1'b0;
    rd      = 1'b0;
    state_d = state_q;

    tick    = (state_q == S_RUN) && (cnt_q == '0);
    consume = tick && valid_q;
    // Never fetch beyond a buffered last-flagged word.
    rd      = (state_q != S_IDLE) && !pend_q && !bus.fifo_empty &&
              (!valid_q || consume) && !(valid_q && buf_last_q);

    unique case (state_q)
      S_IDLE:  if (start) state_d = S_PRIME;
      S_PRIME: if (pend_q) state_d = S_RUN;
      S_RUN:   if (consume && buf_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (stop) state_d = S_IDLE;
  end

  // Datapath: buffer, divider, DAC output and status.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      per_q       <= DIV_W'(1);
      cnt_q       <= '0;
      buf_q       <= '0;
      buf_last_q  <= 1'b0;
      valid_q     <= 1'b0;
      pend_q      <= 1'b0;
      emit_last_q <= 1'b0;
      bus.dac_d      <= IDLE_CODE;
      bus.dac_strobe <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
      sample_cnt  <= '0;
    end else begin
      bus.dac_strobe <= 1'b0;
      emit_last_q    <= 1'b0;
      // done trails the final strobe by one cycle; a stop in between cancels it.
      done           <= emit_last_q && !stop;

      if (stop) begin
        bus.dac_d <= IDLE_CODE;
        valid_q   <= 1'b0;
        pend_q    <= 1'b0;
        cnt_q     <= '0;
      end else begin
        // rd is never raised while a read is pending, so pend simply follows rd.
        pend_q <= rd;

        if (pend_q) begin
          buf_q      <= bus.fifo_q[13:0];
          buf_last_q <= bus.fifo_q[15];
          valid_q    <= 1'b1;
        end else if (consume) begin
          valid_q <= 1'b0;
        end

        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              per_q      <= (rate_div == '0) ? DIV_W'(1) : rate_div;
              underrun   <= 1'b0;
              sample_cnt <= '0;
            end
          end
          S_PRIME: begin
            cnt_q <= '0;
          end
          S_RUN: begin
            if (tick) begin
              cnt_q <= per_q;
            end else begin
              cnt_q <= cnt_q - DIV_W'(1);
            end
            if (consume) begin
              bus.dac_d      <= buf_q;
              bus.dac_strobe <= 1'b1;
              emit_last_q    <= buf_last_q;
              sample_cnt     <= sample_cnt + 24'd1;
            end else if (tick) begin
              underrun <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_stream_player.sv
// Directed bench for dac_stream_player with a FIFO model and a scoreboard of
// expected DAC samples.
module tb_dac_stream_player;

  logic        sys_clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] rate_div;
  logic        busy;
  logic        done;
  logic        underrun;
  logic [23:0] sample_cnt;

  dac_stream_player_if bus ();

  dac_stream_player #(.DIV_W(16), .IDLE_CODE(14'h2000)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .rate_div   (rate_div),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun),
    .sample_cnt (sample_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [15:0] fifo[$];
  logic [15:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  int prev_cyc = 0;
  bit have_prev = 0;
  int exp_per = 0;
  bit exp_done = 0;
  bit last_rd = 0;
  int rd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] w, input bit expect_out);
    fifo.push_back(w);
    if (expect_out) exp_q.push_back(w);
    bus.fifo_empty = (fifo.size() == 0);
  endtask

  // One clock cycle: FIFO model, then monitor/scoreboard.
  task automatic cyc();
    logic        rd;
    logic [15:0] w;
    bit          nxt_done;
    nxt_done = 0;
    @(negedge sys_clk);
    rd = bus.fifo_rdreq;
    @(posedge sys_clk);
    #1;
    cyc_no++;
    last_rd = rd;
    if (rd === 1'b1) begin
      rd_cnt++;
      if (fifo.size() > 0) bus.fifo_q = fifo.pop_front();
    end
    bus.fifo_empty = (fifo.size() == 0);
    if (bus.dac_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("extra_strobe", 32'(bus.dac_strobe), 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("dac_d", 32'(bus.dac_d), 32'(w[13:0]));
        nxt_done = w[15];
        if (exp_per != 0 && have_prev) chk("period", cyc_no - prev_cyc, exp_per);
        prev_cyc  = cyc_no;
        have_prev = 1;
      end
    end
    chk("done", 32'(done), 32'(exp_done));
    exp_done = nxt_done;
  endtask

  task automatic start_play(input logic [15:0] r);
    rate_div  = r;
    start     = 1'b1;
    have_prev = 0;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int got;
    got = 0;
    for (int k = 0; k < budget && got < n; k++) begin
      cyc();
      if (bus.dac_strobe === 1'b1) got++;
    end
    if (got < n) chk("strobe_timeout", got, n);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      cyc();
      if (done === 1'b1) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int rd0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    rate_div = '0;
    bus.fifo_q = '0;
    bus.fifo_empty = 1'b1;

    // Reset
    cyc();
    cyc();
    chk("rst_dac_d", 32'(bus.dac_d), 32'h2000);
    chk("rst_strobe", 32'(bus.dac_strobe), 32'd0);
    chk("rst_rdreq", 32'(bus.fifo_rdreq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    rst = 1'b0;
    cyc();

    // Steady stream, period 4; the word after the last flag must stay queued
    push(16'h0001, 1); push(16'h0002, 1); push(16'h0003, 1); push(16'h8004, 1);
    push(16'h0005, 0);
    exp_per = 4;
    start_play(16'd3);
    wait_done(80);
    chk("steady_cnt", 32'(sample_cnt), 32'd4);
    chk("steady_underrun", 32'(underrun), 32'd0);
    chk("steady_dac_d", 32'(bus.dac_d), 32'h0004);
    chk("steady_busy", 32'(busy), 32'd0);
    chk("steady_fifo_left", fifo.size(), 1);
    chk("steady_exp_left", exp_q.size(), 0);
    fifo.delete();
    bus.fifo_empty = 1'b1;
    cyc();

    // Max rate: rate_div=0 behaves as 1, period 2
    for (int i = 1; i <= 7; i++) push(16'h0100 + 16'(i), 1);
    push(16'h8108, 1);
    exp_per = 2;
    start_play(16'd0);
    wait_done(60);
    chk("max_underrun", 32'(underrun), 32'd0);
    chk("max_cnt", 32'(sample_cnt), 32'd8);
    cyc();

    // Underrun then resume
    exp_per = 0;
    push(16'h0011, 1); push(16'h0012, 1);
    start_play(16'd2);
    wait_strobes(2, 40);
    for (int i = 0; i < 6; i++) cyc();
    chk("ur_flag", 32'(underrun), 32'd1);
    chk("ur_dac_hold", 32'(bus.dac_d), 32'h0012);
    chk("ur_busy", 32'(busy), 32'd1);
    push(16'h8013, 1);
    wait_done(40);
    chk("ur_sticky", 32'(underrun), 32'd1);
    chk("ur_cnt", 32'(sample_cnt), 32'd3);
    chk("ur_dac_d", 32'(bus.dac_d), 32'h0013);
    cyc();

    // Stop in the cycle after a read: that word is discarded
    exp_per = 6;
    push(16'h0021, 1); push(16'h0022, 1); push(16'h0023, 1); push(16'h8024, 1);
    start_play(16'd5);
    wait_strobes(1, 40);
    chk("rd_before_stop", 32'(last_rd), 32'd1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    void'(exp_q.pop_front());
    chk("stop_dac_d", 32'(bus.dac_d), 32'h2000);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_cnt", 32'(sample_cnt), 32'd1);
    for (int i = 0; i < 3; i++) cyc();
    chk("stop_idle_busy", 32'(busy), 32'd0);
    start_play(16'd5);
    wait_done(60);
    chk("restart_cnt", 32'(sample_cnt), 32'd2);
    chk("restart_dac_d", 32'(bus.dac_d), 32'h0024);
    cyc();

    // start+stop together stays idle; start during RUN is ignored
    push(16'h0031, 1); push(16'h0041, 1); push(16'h0042, 1); push(16'h8043, 1);
    rd0 = rd_cnt;
    rate_div = 16'd4;
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("ss_busy", 32'(busy), 32'd0);
    chk("ss_no_rd", rd_cnt - rd0, 0);
    chk("ss_fifo", fifo.size(), 4);
    exp_per = 5;
    start_play(16'd4);
    wait_strobes(1, 40);
    rate_div = 16'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(60);
    chk("rerun_cnt", 32'(sample_cnt), 32'd4);
    chk("rerun_exp_left", exp_q.size(), 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
